// File: rtl/kbd_message_buffer.sv
// Keyboard line editor with a ring of committed message slots.
// Characters build an edit line; Enter or a save edge commits it to the next slot.
module kbd_message_buffer #(
  parameter int CHARS = 16,
  parameter int SLOTS = 5,
  parameter int WRAP  = 1
) (
  input  logic                                        clock_65mhz,
  input  logic                                        reset_n,
  input  logic [7:0]                                  ascii,
  input  logic                                        char_rdy,
  input  logic                                        save,
  input  logic                                        clear,
  output logic [CHARS*8-1:0]                          cstring,
  output logic [$clog2(CHARS+1)-1:0]                  cursor,
  output logic [SLOTS*CHARS*8-1:0]                    messageout,
  output logic [((SLOTS > 1) ? $clog2(SLOTS) : 1)-1:0] wr_slot,
  output logic [$clog2(SLOTS+1)-1:0]                  msg_count,
  output logic                                        line_full,
  output logic                                        reject
);
  localparam int CW = $clog2(CHARS + 1);
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int MW = $clog2(SLOTS + 1);
  localparam int IW = $clog2(CHARS);

  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_SP = 8'h20;

  // Empty-slot marker: "[" first, "]" last, spaces between.
  function automatic logic [CHARS*8-1:0] blank_line();
    logic [CHARS*8-1:0] b;
    b = '0;
    for (int i = 0; i < CHARS; i++)
      b[8*(CHARS-1-i) +: 8] = (i == 0) ? 8'h5B : (i == CHARS - 1) ? 8'h5D : ASCII_SP;
    return b;
  endfunction

  localparam logic [CHARS*8-1:0] BLANK = blank_line();

  logic [7:0]         line     [CHARS];
  logic [CHARS*8-1:0] slot_mem [SLOTS];
  logic               save_q;
  logic               save_edge;
  logic               is_enter;
  logic               commit_req;
  logic               store_full;
  logic               commit_ok;
  logic               char_lost;

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    save_edge  = save & ~save_q;
    is_enter   = char_rdy && (ascii == ASCII_CR);
    commit_req = is_enter || save_edge;
    store_full = (msg_count == MW'(SLOTS));
    commit_ok  = commit_req && !(store_full && (WRAP == 0));
    char_lost  = char_rdy && !is_enter && commit_req;
  end

  assign line_full = (cursor == CW'(CHARS));

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_65mhz) begin
    if (!reset_n) begin
      save_q    <= 1'b0;
      reject    <= 1'b0;
      cursor    <= '0;
      wr_slot   <= '0;
      msg_count <= '0;
      for (int i = 0; i < CHARS; i++) line[i] <= ASCII_SP;
      // NOTE: slot contents are reset, not only the pointers, because blank slots are visible.
      for (int k = 0; k < SLOTS; k++) slot_mem[k] <= BLANK;
    end else begin
      save_q <= save;
      reject <= 1'b0;

      if (clear) begin
        for (int k = 0; k < SLOTS; k++) slot_mem[k] <= BLANK;
        wr_slot   <= '0;
        msg_count <= '0;
      end else if (commit_ok) begin
        slot_mem[wr_slot] <= cstring;
        wr_slot           <= (wr_slot == SW'(SLOTS - 1)) ? '0 : wr_slot + SW'(1);
        if (!store_full) msg_count <= msg_count + MW'(1);
      end

      // A commit request owns the line this cycle; any coincident character is dropped.
      if (commit_req) begin
        if (commit_ok && !clear) begin
          for (int i = 0; i < CHARS; i++) line[i] <= ASCII_SP;
          cursor <= '0;
        end
        if ((!commit_ok && !clear) || char_lost) reject <= 1'b1;
      end else if (char_rdy) begin
        if (ascii == ASCII_BS) begin
          if (cursor != '0) begin
            line[IW'(cursor - CW'(1))] <= ASCII_SP;
            cursor                     <= cursor - CW'(1);
          end
        end else if (!line_full) begin
          line[cursor[IW-1:0]] <= ascii;
          cursor               <= cursor + CW'(1);
        end else begin
          reject <= 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < CHARS; i++) begin : g_line
    assign cstring[8*(CHARS-1-i) +: 8] = line[i];
  end

  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    assign messageout[CHARS*8*k +: CHARS*8] = slot_mem[k];
  end

endmodule

// File: tb/tb_kbd_message_buffer.sv
// Scoreboard bench for kbd_message_buffer: default, no-wrap and 8x3 instances share stimulus.
// Expectations are queued as stimulus is driven and compared one edge later.
module tb_kbd_message_buffer;
  logic       clk = 1'b0;
  logic       reset_n, char_rdy, save, clear;
  logic [7:0] ascii;

  logic [127:0] cs0, cs1;
  logic [4:0]   cur0, cur1;
  logic [639:0] msg0, msg1;
  logic [2:0]   wr0, wr1, cnt0, cnt1;
  logic         full0, full1, rej0, rej1;

  logic [63:0]  cs2;
  logic [3:0]   cur2;
  logic [191:0] msg2;
  logic [1:0]   wr2, cnt2;
  logic         full2, rej2;

  always #5 clk = ~clk;

  kbd_message_buffer #(.CHARS(16), .SLOTS(5), .WRAP(1)) dut0 (
    .clock_65mhz(clk), .reset_n(reset_n), .ascii(ascii), .char_rdy(char_rdy), .save(save),
    .clear(clear), .cstring(cs0), .cursor(cur0), .messageout(msg0), .wr_slot(wr0),
    .msg_count(cnt0), .line_full(full0), .reject(rej0));

  kbd_message_buffer #(.CHARS(16), .SLOTS(5), .WRAP(0)) dut1 (
    .clock_65mhz(clk), .reset_n(reset_n), .ascii(ascii), .char_rdy(char_rdy), .save(save),
    .clear(clear), .cstring(cs1), .cursor(cur1), .messageout(msg1), .wr_slot(wr1),
    .msg_count(cnt1), .line_full(full1), .reject(rej1));

  kbd_message_buffer #(.CHARS(8), .SLOTS(3), .WRAP(1)) dut2 (
    .clock_65mhz(clk), .reset_n(reset_n), .ascii(ascii), .char_rdy(char_rdy), .save(save),
    .clear(clear), .cstring(cs2), .cursor(cur2), .messageout(msg2), .wr_slot(wr2),
    .msg_count(cnt2), .line_full(full2), .reject(rej2));

  typedef enum {CS, CUR, SLOT, WR, CNT, FULL, REJ} sel_e;
  typedef struct {
    string        tag;
    int           dut;
    sel_e         sel;
    int           idx;
    logic [127:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want_v);
    checks++;
    if (got === want_v) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, want_v);
  endtask

  function automatic logic [127:0] observe(input int dut, input sel_e sel, input int idx);
    logic [127:0] r;
    r = '0;
    if (dut == 0) begin
      case (sel)
        CS:      r = cs0;
        CUR:     r = 128'(cur0);
        SLOT:    r = msg0[128*idx +: 128];
        WR:      r = 128'(wr0);
        CNT:     r = 128'(cnt0);
        FULL:    r = 128'(full0);
        default: r = 128'(rej0);
      endcase
    end else if (dut == 1) begin
      case (sel)
        CS:      r = cs1;
        CUR:     r = 128'(cur1);
        SLOT:    r = msg1[128*idx +: 128];
        WR:      r = 128'(wr1);
        CNT:     r = 128'(cnt1);
        FULL:    r = 128'(full1);
        default: r = 128'(rej1);
      endcase
    end else begin
      case (sel)
        CS:      r = 128'(cs2);
        CUR:     r = 128'(cur2);
        SLOT:    r = 128'(msg2[64*idx +: 64]);
        WR:      r = 128'(wr2);
        CNT:     r = 128'(cnt2);
        FULL:    r = 128'(full2);
        default: r = 128'(rej2);
      endcase
    end
    return r;
  endfunction

  // Line of n characters: s first, space padded, first character in the top byte.
  function automatic logic [127:0] text(input string s, input int n);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < n; i++)
      r[8*(n-1-i) +: 8] = (i < s.len()) ? s[i] : 8'h20;
    return r;
  endfunction

  function automatic logic [127:0] blank(input int n);
    logic [127:0] r;
    r = text("", n);
    r[8*(n-1) +: 8] = 8'h5B;
    r[7:0]          = 8'h5D;
    return r;
  endfunction

  task automatic want(input string tag, input int dut, input sel_e sel, input int idx,
                      input logic [127:0] val);
    exp_t e;
    e.tag = tag; e.dut = dut; e.sel = sel; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.dut, e.sel, e.idx), e.val);
    end
  endtask

  task automatic key(input logic [7:0] c);
    ascii    = c;
    char_rdy = 1'b1;
    cycle();
    char_rdy = 1'b0;
    ascii    = 8'h00;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    string s;
    reset_n = 1'b0; char_rdy = 1'b0; save = 1'b0; clear = 1'b0; ascii = 8'h00;

    want("rst_cs", 0, CS, 0, text("", 16));
    want("rst_cursor", 0, CUR, 0, 0);
    want("rst_wr", 0, WR, 0, 0);
    want("rst_cnt", 0, CNT, 0, 0);
    want("rst_full", 0, FULL, 0, 0);
    want("rst_rej", 0, REJ, 0, 0);
    want("rst_slot0", 0, SLOT, 0, blank(16));
    want("rst_slot4", 0, SLOT, 4, blank(16));
    want("rst_small_slot2", 2, SLOT, 2, blank(8));
    do_reset();

    key(8'h48);
    key(8'h49);
    want("hi_slot0", 0, SLOT, 0, text("HI", 16));
    want("hi_wr", 0, WR, 0, 1);
    want("hi_cnt", 0, CNT, 0, 1);
    want("hi_cursor", 0, CUR, 0, 0);
    want("hi_cs_blank", 0, CS, 0, text("", 16));
    want("hi_small_slot0", 2, SLOT, 0, text("HI", 8));
    key(8'h0D);

    key(8'h5A);
    want("clr_cnt", 0, CNT, 0, 0);
    want("clr_wr", 0, WR, 0, 0);
    want("clr_slot0", 0, SLOT, 0, blank(16));
    want("clr_line_kept", 0, CS, 0, text("Z", 16));
    want("clr_cursor_kept", 0, CUR, 0, 1);
    clear = 1'b1;
    cycle();
    clear = 1'b0;

    want("bs_cursor", 0, CUR, 0, 0);
    want("bs_cs", 0, CS, 0, text("", 16));
    key(8'h08);
    want("bs_empty_cursor", 0, CUR, 0, 0);
    want("bs_empty_norej", 0, REJ, 0, 0);
    key(8'h08);

    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        want("fill_cursor", 0, CUR, 0, 16);
        want("fill_full", 0, FULL, 0, 1);
        want("fill_norej", 0, REJ, 0, 0);
      end
      key(8'h41);
    end
    want("over_rej", 0, REJ, 0, 1);
    want("over_cursor", 0, CUR, 0, 16);
    want("over_cs", 0, CS, 0, text("AAAAAAAAAAAAAAAA", 16));
    key(8'h41);
    want("over_rej_pulse", 0, REJ, 0, 0);
    cycle();
    want("full_bs_cursor", 0, CUR, 0, 15);
    want("full_bs_full", 0, FULL, 0, 0);
    want("full_bs_cs", 0, CS, 0, text("AAAAAAAAAAAAAAA", 16));
    key(8'h08);

    do_reset();
    for (int n = 1; n <= 6; n++) begin
      key(8'h30 + 8'(n));
      if (n == 6) begin
        want("wrap_slot0", 0, SLOT, 0, text("6", 16));
        want("wrap_slot1", 0, SLOT, 1, text("2", 16));
        want("wrap_slot4", 0, SLOT, 4, text("5", 16));
        want("wrap_cnt", 0, CNT, 0, 5);
        want("wrap_wr", 0, WR, 0, 1);
        want("wrap_norej", 0, REJ, 0, 0);
        want("nowrap_rej", 1, REJ, 0, 1);
        want("nowrap_slot0", 1, SLOT, 0, text("1", 16));
        want("nowrap_slot4", 1, SLOT, 4, text("5", 16));
        want("nowrap_cnt", 1, CNT, 0, 5);
        want("nowrap_wr", 1, WR, 0, 0);
        want("nowrap_line_kept", 1, CS, 0, text("6", 16));
        want("nowrap_cursor", 1, CUR, 0, 1);
        want("small_slot0", 2, SLOT, 0, text("4", 8));
        want("small_slot2", 2, SLOT, 2, text("6", 8));
        want("small_wr", 2, WR, 0, 0);
        want("small_cnt", 2, CNT, 0, 3);
      end
      key(8'h0D);
    end

    do_reset();
    key(8'h53);
    save = 1'b1;
    want("save_cnt", 0, CNT, 0, 1);
    want("save_slot0", 0, SLOT, 0, text("S", 16));
    want("save_cursor", 0, CUR, 0, 0);
    cycle();
    for (int i = 1; i < 10; i++) begin
      if (i == 9) begin
        s = "held_";
        want({s, "cnt"}, 0, CNT, 0, 1);
        want({s, "wr"}, 0, WR, 0, 1);
      end
      cycle();
    end
    save = 1'b0;
    cycle();
    ascii = 8'h51; char_rdy = 1'b1; save = 1'b1;
    want("coin_rej", 0, REJ, 0, 1);
    want("coin_cnt", 0, CNT, 0, 2);
    want("coin_slot1", 0, SLOT, 1, text("", 16));
    want("coin_cs", 0, CS, 0, text("", 16));
    want("coin_cursor", 0, CUR, 0, 0);
    cycle();
    char_rdy = 1'b0; save = 1'b0; ascii = 8'h00;
    cycle();

    key(8'h41);
    key(8'h42);
    key(8'h43);
    want("mid_cursor", 2, CUR, 0, 4);
    want("mid_cs", 2, CS, 0, text("ABCD", 8));
    key(8'h44);
    reset_n = 1'b0; ascii = 8'h0D; char_rdy = 1'b1;
    want("mrst_cs", 2, CS, 0, text("", 8));
    want("mrst_cursor", 2, CUR, 0, 0);
    want("mrst_slot0", 2, SLOT, 0, blank(8));
    want("mrst_slot1", 2, SLOT, 1, blank(8));
    want("mrst_slot2", 2, SLOT, 2, blank(8));
    want("mrst_wr", 2, WR, 0, 0);
    want("mrst_cnt", 2, CNT, 0, 0);
    want("mrst_full", 2, FULL, 0, 0);
    want("mrst_rej", 2, REJ, 0, 0);
    want("mrst_big_cnt", 0, CNT, 0, 0);
    cycle();
    reset_n = 1'b1; char_rdy = 1'b0; ascii = 8'h00;
    cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/kbd_message_buffer.md
KBD_MESSAGE_BUFFER -- requirements
Module: kbd_message_buffer

Interface
REQ-001 Parameter CHARS, default 16: characters per line; legal range 2..64.
REQ-002 Parameter SLOTS, default 5: number of stored message slots; legal range 1..16.
REQ-003 Parameter WRAP, default 1: 1 means a full store overwrites the oldest slot; 0 means a full store rejects further commits.
REQ-004 clock_65mhz  in  1: the single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1: synchronous, active-low reset, sampled on the rising edge of clock_65mhz.
REQ-006 ascii  in  8: character code, valid only while char_rdy=1.
REQ-007 char_rdy  in  1: one-cycle strobe indicating a new character on ascii.
REQ-008 save  in  1: level input; each rising edge is a commit request.
REQ-009 clear  in  1: when 1, re-initialise every slot to the blank pattern and empty the store.
REQ-010 cstring  out  CHARS*8: current edit line; character i (i=0 is first typed) occupies bits [8*(CHARS-1-i)+7 : 8*(CHARS-1-i)].
REQ-011 cursor  out  clog2(CHARS+1): number of characters in the edit line, 0..CHARS.
REQ-012 messageout  out  SLOTS*CHARS*8: slot k occupies bits [CHARS*8*(k+1)-1 : CHARS*8*k].
REQ-013 wr_slot  out  clog2(SLOTS) (min 1): index of the next slot to be written.
REQ-014 msg_count  out  clog2(SLOTS+1): number of occupied slots, saturating at SLOTS.
REQ-015 line_full  out  1: high while cursor==CHARS.
REQ-016 reject  out  1: one-cycle pulse when a character or commit is discarded.

Function
REQ-017 Printable char (ascii not 0x08, not 0x0D) with cursor<CHARS: writes at position cursor, cursor+1; visible the cycle after the strobe.
REQ-018 Printable char with cursor==CHARS: line unchanged, reject pulses.
REQ-019 Backspace 0x08 with cursor>0: position cursor-1 set to 0x20, cursor-1; with cursor==0: no change, no reject.
REQ-020 Enter 0x0D strobe, or save rising edge (save=1 while the registered previous save=0), is a commit request.
REQ-021 Commit: slot wr_slot <= cstring; wr_slot advances, wrapping SLOTS-1->0; msg_count+1, saturating at SLOTS; cstring <= all 0x20; cursor <= 0; all in the same edge.
REQ-022 Commit with msg_count==SLOTS and WRAP=1: overwrite slot wr_slot, which is the oldest, then advance; msg_count stays SLOTS.
REQ-023 Commit with msg_count==SLOTS and WRAP=0: slots, wr_slot and the line are unchanged; reject pulses.
REQ-024 Commit with cursor==0 still commits an all-space line.
REQ-025 char_rdy and save edge in the same cycle: the commit wins, the character is discarded, reject pulses.
REQ-026 clear=1: all slots take the blank pattern, wr_slot=0, msg_count=0; the edit line is unaffected; clear has priority over a commit in the same cycle.
REQ-027 Blank pattern: byte 0 '[' (0x5B), byte CHARS-1 ']' (0x5D), all other bytes 0x20.
REQ-028 A held save level produces exactly one commit; the next commit requires save to return to 0.

Reset
REQ-029 reset_n=0 at a clock edge: cstring all 0x20, cursor=0, all slots blank, wr_slot=0, msg_count=0, line_full=0, reject=0, save edge register=0.
REQ-030 Reset takes priority over all inputs, including mid-line and mid-commit, and discards any pending commit.

Verification
REQ-031 Defaults; type "HI" then Enter -> slot 0 = "HI" followed by 14 spaces; wr_slot=1; msg_count=1; cursor=0.
REQ-032 Type 17 chars 'A' -> cursor=16; line_full=1; reject pulses once on the 17th; backspace -> cursor=15, byte 15 = 0x20.
REQ-033 WRAP=1: 6 commits "1".."6" -> slot0="6", slots1-4="2".."5", msg_count=5, wr_slot=1; WRAP=0 -> 6th rejected, slot0="1".
REQ-034 Hold save high 10 cycles -> exactly one commit; char_rdy coincident with the save edge -> char dropped, reject=1.
REQ-035 CHARS=8, SLOTS=3; reset_n low mid-line after 4 chars -> all outputs at reset values, slots "[      ]".
